// File: rtl/scramble_checker_pkg.sv
// Shared definitions for the scramble checker: FSM state encoding,
// move index width, slot count and the base scramble length.
package scramble_checker_pkg;

    // Width of one move index, matching the scrambler index1..index6 outputs.
    localparam int IDX_W    = 3;
    // Number of scramble slots delivered by the scrambler.
    localparam int N_IDX    = 6;
    // Scramble length is mode + LEN_BASE (mode 0 -> 3 moves).
    localparam int LEN_BASE = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    // Number of moves for a given mode, in the 3-bit moves_left width.
    function automatic logic [2:0] len_of(input logic [1:0] m);
        return {1'b0, m} + 3'(LEN_BASE);
    endfunction

endpackage

// File: rtl/scramble_checker_timer.sv
// move_timer: idle-cycle counter for the scramble checker.
// Ports: clk, rst (async, active-high), clr_i (sync clear to 0),
//        expired_o (count has reached TIMEOUT-1).
module move_timer #(
    parameter int TIMEOUT = 50_000_000,
    parameter int TO_W    = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic expired_o
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (!expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/scramble_checker.sv
// scramble_checker: captures a scramble on scr_done and checks the player's
// moves against it replayed last-to-first, reporting progress and verdict.
// Ports: clk, rst (async, active-high); scr_done/mode/index1..6 from the
//        scrambler; move_valid/move_idx from the player; clear abandons.
//        Outputs expect_idx, moves_left, err_cnt, busy, solved, failed.
module scramble_checker
    import scramble_checker_pkg::*;
#(
    parameter int MAX_ERR = 2,
    parameter int TIMEOUT = 50_000_000,
    parameter int TO_W    = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scr_done,
    input  logic [1:0]       mode,
    input  logic [IDX_W-1:0] index1,
    input  logic [IDX_W-1:0] index2,
    input  logic [IDX_W-1:0] index3,
    input  logic [IDX_W-1:0] index4,
    input  logic [IDX_W-1:0] index5,
    input  logic [IDX_W-1:0] index6,
    input  logic             move_valid,
    input  logic [IDX_W-1:0] move_idx,
    input  logic             clear,
    output logic [IDX_W-1:0] expect_idx,
    output logic [2:0]       moves_left,
    output logic [1:0]       err_cnt,
    output logic             busy,
    output logic             solved,
    output logic             failed
);

    state_e                        state_q, state_d;
    logic [N_IDX-1:0][IDX_W-1:0]   slot_q, slot_d;
    logic [2:0]                    ptr_q, ptr_d;
    logic [2:0]                    left_q, left_d;
    logic [1:0]                    err_q, err_d;
    logic [IDX_W-1:0]              exp_q, exp_d;

    logic [N_IDX-1:0][IDX_W-1:0]   idx_in;
    logic [2:0]                    new_len;
    logic                          hit;
    logic                          tmr_clr;
    logic                          tmr_exp;

    assign idx_in  = {index6, index5, index4, index3, index2, index1};
    assign new_len = len_of(mode);
    assign hit     = (move_idx == slot_q[ptr_q]);

    // The timer only runs in PLAY and restarts on every move, right or
    // wrong, as well as on reload or abandon.
    assign tmr_clr = clear || scr_done || move_valid || (state_q != ST_PLAY);

    move_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (tmr_clr),
        .expired_o (tmr_exp)
    );

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        ptr_d   = ptr_q;
        left_d  = left_q;
        err_d   = err_q;
        exp_d   = exp_q;

        if (clear) begin
            state_d = ST_IDLE;
            slot_d  = '0;
            ptr_d   = '0;
            left_d  = '0;
            err_d   = '0;
            exp_d   = '0;
        end else if (scr_done) begin
            // Replay starts from the last move of the scramble.
            state_d = ST_PLAY;
            slot_d  = idx_in;
            ptr_d   = new_len - 3'd1;
            left_d  = new_len;
            err_d   = '0;
            exp_d   = idx_in[new_len - 3'd1];
        end else if (state_q == ST_PLAY) begin
            if (move_valid) begin
                if (hit) begin
                    left_d = left_q - 3'd1;
                    if (left_q == 3'd1) begin
                        state_d = ST_WIN;
                        exp_d   = '0;
                    end else begin
                        ptr_d = ptr_q - 3'd1;
                        exp_d = slot_q[ptr_q - 3'd1];
                    end
                end else begin
                    err_d = err_q + 2'd1;
                    if (err_q == 2'(MAX_ERR)) begin
                        state_d = ST_FAIL;
                        exp_d   = '0;
                    end
                end
            end else if (tmr_exp) begin
                state_d = ST_FAIL;
                exp_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            ptr_q   <= '0;
            left_q  <= '0;
            err_q   <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            ptr_q   <= ptr_d;
            left_q  <= left_d;
            err_q   <= err_d;
            exp_q   <= exp_d;
        end
    end

    assign expect_idx = exp_q;
    assign moves_left = left_q;
    assign err_cnt    = err_q;
    assign busy       = (state_q == ST_PLAY);
    assign solved     = (state_q == ST_WIN);
    assign failed     = (state_q == ST_FAIL);

endmodule

// File: tb/tb_scramble_checker.sv
// Directed bench for scramble_checker: a vector table for single-cycle
// behaviour plus hand-written timeout and async-reset sequences.
module tb_scramble_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scr_done = 1'b0;
    logic [1:0] mode = '0;
    logic [2:0] index1 = '0, index2 = '0, index3 = '0;
    logic [2:0] index4 = '0, index5 = '0, index6 = '0;
    logic       move_valid = 1'b0;
    logic [2:0] move_idx = '0;
    logic       clear = 1'b0;
    logic [2:0] expect_idx;
    logic [2:0] moves_left;
    logic [1:0] err_cnt;
    logic       busy, solved, failed;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    scramble_checker #(
        .MAX_ERR (2),
        .TIMEOUT (20),
        .TO_W    (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scr_done   (scr_done),
        .mode       (mode),
        .index1     (index1),
        .index2     (index2),
        .index3     (index3),
        .index4     (index4),
        .index5     (index5),
        .index6     (index6),
        .move_valid (move_valid),
        .move_idx   (move_idx),
        .clear      (clear),
        .expect_idx (expect_idx),
        .moves_left (moves_left),
        .err_cnt    (err_cnt),
        .busy       (busy),
        .solved     (solved),
        .failed     (failed)
    );

    // {expect_idx, moves_left, err_cnt, busy, solved, failed}
    function automatic logic [10:0] pack(input logic [2:0] e, input logic [2:0] ml,
                                         input logic [1:0] er, input logic b,
                                         input logic s, input logic f);
        return {e, ml, er, b, s, f};
    endfunction

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = {expect_idx, moves_left, err_cnt, busy, solved, failed};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got exp=%0d left=%0d err=%0d b/s/f=%b%b%b, want exp=%0d left=%0d err=%0d b/s/f=%b%b%b",
                     name, act[10:8], act[7:5], act[4:3], act[2], act[1], act[0],
                     exp[10:8], exp[7:5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // One clock of stimulus; pulses drop after the edge.
    task automatic step(input logic sd, input logic [1:0] md, input logic [17:0] ix,
                        input logic mv, input logic [2:0] mi, input logic cl);
        @(negedge clk);
        scr_done   = sd;
        mode       = md;
        {index6, index5, index4, index3, index2, index1} = ix;
        move_valid = mv;
        move_idx   = mi;
        clear      = cl;
        @(posedge clk);
        #1;
        scr_done   = 1'b0;
        move_valid = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 18'd0, 1'b0, 3'd0, 1'b0);
    endtask

    typedef struct {
        string       name;
        logic        sd;
        logic [1:0]  md;
        logic [17:0] ix;
        logic        mv;
        logic [2:0]  mi;
        logic        cl;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [17:0] ix6(input logic [2:0] a1, input logic [2:0] a2,
                                        input logic [2:0] a3, input logic [2:0] a4,
                                        input logic [2:0] a5, input logic [2:0] a6);
        return {a6, a5, a4, a3, a2, a1};
    endfunction

    initial begin
        // Test 1: mode 0, {1,4,2}, solved by entering 2,4,1
        vecs.push_back('{"t1_load", 1, 2'd0, ix6(1,4,2,0,0,0), 0, 0, 0, pack(2,3,0,1,0,0)});
        vecs.push_back('{"t1_mv2",  0, 2'd0, 18'd0, 1, 3'd2, 0, pack(4,2,0,1,0,0)});
        vecs.push_back('{"t1_mv4",  0, 2'd0, 18'd0, 1, 3'd4, 0, pack(1,1,0,1,0,0)});
        vecs.push_back('{"t1_mv1",  0, 2'd0, 18'd0, 1, 3'd1, 0, pack(0,0,0,0,1,0)});
        vecs.push_back('{"t1_hold", 0, 2'd0, 18'd0, 0, 3'd0, 0, pack(0,0,0,0,1,0)});
        // Test 6: clear from WIN, then move in IDLE is ignored
        vecs.push_back('{"t6_clear", 0, 2'd0, 18'd0, 0, 3'd0, 1, pack(0,0,0,0,0,0)});
        vecs.push_back('{"t6_mvidl", 0, 2'd0, 18'd0, 1, 3'd3, 0, pack(0,0,0,0,0,0)});
        // Test 2: mode 3, {3,5,7,0,6,2}, three wrong codes mid-sequence
        vecs.push_back('{"t2_load", 1, 2'd3, ix6(3,5,7,0,6,2), 0, 0, 0, pack(2,6,0,1,0,0)});
        vecs.push_back('{"t2_ok2",  0, 2'd0, 18'd0, 1, 3'd2, 0, pack(6,5,0,1,0,0)});
        vecs.push_back('{"t2_ok6",  0, 2'd0, 18'd0, 1, 3'd6, 0, pack(0,4,0,1,0,0)});
        vecs.push_back('{"t2_bad1", 0, 2'd0, 18'd0, 1, 3'd1, 0, pack(0,4,1,1,0,0)});
        vecs.push_back('{"t2_ok0",  0, 2'd0, 18'd0, 1, 3'd0, 0, pack(7,3,1,1,0,0)});
        vecs.push_back('{"t2_bad2", 0, 2'd0, 18'd0, 1, 3'd4, 0, pack(7,3,2,1,0,0)});
        vecs.push_back('{"t2_bad3", 0, 2'd0, 18'd0, 1, 3'd5, 0, pack(0,3,3,0,0,1)});
        vecs.push_back('{"t2_mvfl", 0, 2'd0, 18'd0, 1, 3'd7, 0, pack(0,3,3,0,0,1)});
        // Test 4: reload from FAIL, then scr_done together with a move
        vecs.push_back('{"t4_load", 1, 2'd1, ix6(1,2,3,4,0,0), 0, 0, 0, pack(4,4,0,1,0,0)});
        vecs.push_back('{"t4_ok4",  0, 2'd0, 18'd0, 1, 3'd4, 0, pack(3,3,0,1,0,0)});
        vecs.push_back('{"t4_sdmv", 1, 2'd2, ix6(5,4,3,2,1,7), 1, 3'd3, 0, pack(1,5,0,1,0,0)});
        vecs.push_back('{"t4_ok1",  0, 2'd0, 18'd0, 1, 3'd1, 0, pack(2,4,0,1,0,0)});
        // clear beats scr_done
        vecs.push_back('{"t4_clsd", 1, 2'd3, ix6(1,1,1,1,1,1), 0, 0, 1, pack(0,0,0,0,0,0)});
        vecs.push_back('{"t4_idle", 0, 2'd0, 18'd0, 0, 3'd0, 0, pack(0,0,0,0,0,0)});

        repeat (3) @(posedge clk);
        #1;
        check("reset", pack(0,0,0,0,0,0));
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].sd, vecs[i].md, vecs[i].ix, vecs[i].mv, vecs[i].mi, vecs[i].cl);
            check(vecs[i].name, vecs[i].exp);
        end

        // Test 3: no moves -> FAIL exactly 20 cycles after scr_done
        step(1'b1, 2'd0, ix6(1,4,2,0,0,0), 1'b0, 3'd0, 1'b0);
        for (int k = 1; k < 20; k++) idle();
        check("t3_c19", pack(2,3,0,1,0,0));
        idle();
        check("t3_c20", pack(0,3,0,0,0,1));

        // A move at cycle 19 restarts the count
        step(1'b1, 2'd0, ix6(1,4,2,0,0,0), 1'b0, 3'd0, 1'b0);
        for (int k = 1; k < 19; k++) idle();
        step(1'b0, 2'd0, 18'd0, 1'b1, 3'd2, 1'b0);
        check("t3_mv19", pack(4,2,0,1,0,0));
        for (int k = 1; k < 20; k++) idle();
        check("t3_r19", pack(4,2,0,1,0,0));
        idle();
        check("t3_r20", pack(0,2,0,0,0,1));

        // Test 5: async reset mid-PLAY
        step(1'b1, 2'd1, ix6(1,2,3,4,0,0), 1'b0, 3'd0, 1'b0);
        step(1'b0, 2'd0, 18'd0, 1'b1, 3'd4, 1'b0);
        check("t5_play", pack(3,3,0,1,0,0));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async", pack(0,0,0,0,0,0));
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 2'd0, 18'd0, 1'b1, 3'd3, 1'b0);
        check("t5_mvidl", pack(0,0,0,0,0,0));
        idle();
        check("t5_stay", pack(0,0,0,0,0,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
